// File: rtl/wasca_switch_debouncer.sv
// Switch synchroniser and per-bit debouncer feeding the switches PIO in_port.
// Optional sticky change latch: define WASCA_SWITCH_EDGE_LATCH_EN.
module wasca_switch_debouncer #(
    parameter int               WIDTH           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               CNT_W           = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_changed,
    output logic             any_changed,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] sw_edge_latched
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] clean_d;
    logic [WIDTH-1:0] changed_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VALUE;
        end else begin
            sync_q[0] <= sw_raw;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Counter clears whenever s agrees with the accepted level or a level is accepted.
    always_comb begin
        clean_d   = sw_clean;
        changed_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != sw_clean[i]) begin
                if (cnt_q[i] == LAST) begin
                    clean_d[i]   = s[i];
                    changed_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_clean    <= RESET_VALUE;
            sw_changed  <= '0;
            any_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sw_clean    <= clean_d;
            sw_changed  <= changed_d;
            any_changed <= |changed_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef WASCA_SWITCH_EDGE_LATCH_EN
    // A new change wins over a coincident clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_edge_latched <= '0;
        end else begin
            sw_edge_latched <= (sw_edge_latched & ~edge_clear) | changed_d;
        end
    end
`else
    logic unused_clear;
    assign unused_clear    = ^edge_clear;
    assign sw_edge_latched = '0;
`endif

endmodule

// File: tb/tb_wasca_switch_debouncer.sv
// Bench for wasca_switch_debouncer: vector table, directed corners and a
// random run against a sample-window reference model.
module tb_wasca_switch_debouncer;

    localparam int         W  = 8;
    localparam int         SS = 2;
    localparam int         D  = 4;
    localparam logic [7:0] RV = 8'h00;
`ifdef WASCA_SWITCH_EDGE_LATCH_EN
    localparam bit LATCH_ON = 1'b1;
`else
    localparam bit LATCH_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] edge_clear = '0;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_changed;
    logic         any_changed;
    logic [W-1:0] sw_edge_latched;

    wasca_switch_debouncer #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D),
        .CNT_W(16), .RESET_VALUE(RV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
        .sw_clean(sw_clean), .sw_changed(sw_changed),
        .any_changed(any_changed), .edge_clear(edge_clear),
        .sw_edge_latched(sw_edge_latched)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raw samples since reset; a bit is accepted when the
    // last D pre-edge synchronised samples all disagree with the accepted level.
    logic [7:0] hist[$];
    logic [7:0] m_clean, m_ch, m_lat;
    logic       m_any;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] s_at(input int j);
        if (j >= SS) return hist[j-SS];
        return RV;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_clean = RV;
        m_ch    = '0;
        m_any   = 1'b0;
        m_lat   = '0;
    endtask

    task automatic tick(input logic [7:0] raw, input logic [7:0] clr);
        int t;
        bit ok;
        logic [7:0] nclean, nch;
        sw_raw     = raw;
        edge_clear = clr;
        t = hist.size();
        hist.push_back(raw);
        nclean = m_clean;
        nch    = '0;
        for (int i = 0; i < W; i++) begin
            ok = (t - D + 1) >= 0;
            for (int j = t - D + 1; ok && j <= t; j++)
                if (s_at(j)[i] == m_clean[i]) ok = 0;
            if (ok) begin
                nclean[i] = ~m_clean[i];
                nch[i]    = 1'b1;
            end
        end
        m_clean = nclean;
        m_ch    = nch;
        m_any   = |nch;
        m_lat   = LATCH_ON ? ((m_lat & ~clr) | nch) : 8'h00;
        @(posedge clk);
        #1;
        chk("model_clean", sw_clean, m_clean);
        chk("model_changed", sw_changed, m_ch);
        chk("model_any", {7'b0, any_changed}, {7'b0, m_any});
        chk("model_latched", sw_edge_latched, m_lat);
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        #1;
        chk("rst_clean", sw_clean, RV);
        chk("rst_changed", sw_changed, 8'h00);
        chk("rst_any", {7'b0, any_changed}, 8'h00);
        chk("rst_latched", sw_edge_latched, 8'h00);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [7:0] raw;
        logic [7:0] clean;
        logic [7:0] ch;
        logic       any;
    } vec_t;

    vec_t tbl[14];
    logic [7:0] r;
    logic [7:0] c;

    initial begin
        tbl[0]  = '{8'h01, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{8'h01, 8'h00, 8'h00, 1'b0};
        tbl[2]  = '{8'h01, 8'h00, 8'h00, 1'b0};
        tbl[3]  = '{8'h01, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{8'h01, 8'h00, 8'h00, 1'b0};
        tbl[5]  = '{8'h01, 8'h01, 8'h01, 1'b1};
        tbl[6]  = '{8'h01, 8'h01, 8'h00, 1'b0};
        tbl[7]  = '{8'hA5, 8'h01, 8'h00, 1'b0};
        tbl[8]  = '{8'hA5, 8'h01, 8'h00, 1'b0};
        tbl[9]  = '{8'hA5, 8'h01, 8'h00, 1'b0};
        tbl[10] = '{8'hA5, 8'h01, 8'h00, 1'b0};
        tbl[11] = '{8'hA5, 8'h01, 8'h00, 1'b0};
        tbl[12] = '{8'hA5, 8'hA5, 8'hA4, 1'b1};
        tbl[13] = '{8'hA5, 8'hA5, 8'h00, 1'b0};

        model_reset();
        #2;
        do_reset(3);

        // Quiet inputs after reset: nothing moves.
        for (int i = 0; i < 20; i++) begin
            tick(8'h00, 8'h00);
            chk("quiet_clean", sw_clean, 8'h00);
            chk("quiet_changed", sw_changed, 8'h00);
        end

        do_reset(2);
        for (int i = 0; i < 14; i++) begin
            tick(tbl[i].raw, 8'h00);
            chk($sformatf("tbl%0d_clean", i), sw_clean, tbl[i].clean);
            chk($sformatf("tbl%0d_changed", i), sw_changed, tbl[i].ch);
            chk($sformatf("tbl%0d_any", i), {7'b0, any_changed},
                {7'b0, tbl[i].any});
        end

        // Bit 3 glitches one cycle short of acceptance, then a stable high.
        do_reset(2);
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 4; i++) begin
                tick((i < 3) ? 8'h08 : 8'h00, 8'h00);
                chk("glitch_clean", sw_clean, 8'h00);
                chk("glitch_changed", sw_changed, 8'h00);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick(8'h08, 8'h00);
            chk("hold3_clean", sw_clean, (i >= 5) ? 8'h08 : 8'h00);
            chk("hold3_changed", sw_changed, (i == 5) ? 8'h08 : 8'h00);
        end

        // All-at-once 00 -> A5.
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            tick(8'hA5, 8'h00);
            chk("a5_clean", sw_clean, (i >= 5) ? 8'hA5 : 8'h00);
            chk("a5_changed", sw_changed, (i == 5) ? 8'hA5 : 8'h00);
            chk("a5_any", {7'b0, any_changed}, (i == 5) ? 8'h01 : 8'h00);
        end

        // Reset two cycles into a pending count on bit 2.
        do_reset(2);
        for (int i = 0; i < 4; i++) tick(8'h04, 8'h00);
        sw_raw = 8'h04;
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            tick(8'h04, 8'h00);
            chk("rst2_clean", sw_clean, (i >= 5) ? 8'h04 : 8'h00);
            chk("rst2_changed", sw_changed, (i == 5) ? 8'h04 : 8'h00);
        end

        // Sticky latch on bit 1: set, hold, clear, clear-vs-set collision.
        do_reset(2);
        for (int i = 0; i < 9; i++) tick(8'h02, 8'h00);
        chk("lat_set", sw_edge_latched, LATCH_ON ? 8'h02 : 8'h00);
        tick(8'h02, 8'h02);
        chk("lat_clr", sw_edge_latched, 8'h00);
        for (int i = 0; i < 6; i++) begin
            tick(8'h00, (i == 5) ? 8'h02 : 8'h00);
            chk("lat_coll_changed", sw_changed, (i == 5) ? 8'h02 : 8'h00);
        end
        chk("lat_coll", sw_edge_latched, LATCH_ON ? 8'h02 : 8'h00);

        // Random run with slow-changing inputs and occasional resets.
        r = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) r = 8'($urandom);
            c = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(599) == 0) do_reset($urandom_range(1, 3));
            tick(r, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wasca_switch_debouncer.md
Name: wasca_switch_debouncer

Overview:
Upstream conditioning stage for the switches PIO. It synchronises raw board switch inputs into clk and debounces each bit independently. It drives a clean, glitch-free vector onto the PIO in_port, which the PIO samples every cycle into readdata. It also emits per-bit change pulses for optional interrupt or edge logic.

Parameters:
WIDTH, 8, number of switch bits (matches PIO in_port width)
SYNC_STAGES, 2, flip-flops in each bit's metastability synchroniser (legal 2..4)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a level is accepted (1 ms at 50 MHz; legal >= 1)
CNT_W, 16, per-bit counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES
RESET_VALUE, 0, WIDTH-bit value of sw_clean and synchroniser flops in reset

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous, active-low
sw_raw  in  WIDTH  asynchronous raw switch pins
sw_clean  out  WIDTH  debounced level, registered; feeds PIO in_port
sw_changed  out  WIDTH  one-cycle pulse per bit when that bit of sw_clean updates
any_changed  out  1  registered OR of the per-bit change flags, coincident with sw_changed
edge_clear  in  WIDTH  per-bit clear strobe for sticky edge latch (optional feature)
sw_edge_latched  out  WIDTH  sticky per-bit change flags (optional feature)

Behaviour:
- Reset is asynchronous, active-low, clock clk. In reset:
  - sync flops = RESET_VALUE, sw_clean = RESET_VALUE
  - counters = 0
  - sw_changed = 0, any_changed = 0, sw_edge_latched = 0
- Reset asserted mid-count aborts every pending transition. No pulse is generated on reset entry or exit.
- Synchroniser: SYNC_STAGES-deep shift per bit. s = output of the last stage. No logic between stages.
- Per bit i, evaluated every clk edge:
  - s[i] == sw_clean[i]: counter[i] <= 0, no change.
  - s[i] != sw_clean[i] and counter[i] < DEBOUNCE_CYCLES-1: counter[i] <= counter[i]+1.
  - s[i] != sw_clean[i] and counter[i] == DEBOUNCE_CYCLES-1: sw_clean[i] <= s[i], counter[i] <= 0, sw_changed[i] <= 1.
  - sw_changed[i] is 0 on every other edge.
- Any single-cycle return of s[i] to sw_clean[i] restarts the count from 0. Glitches shorter than DEBOUNCE_CYCLES cycles never reach sw_clean.
- Latency: raw level sampled at edge k (first sync stage) and held stable → sw_clean updates at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. With DEBOUNCE_CYCLES=1, sw_clean follows s one cycle later.
- Counters never wrap; the maximum reached value is DEBOUNCE_CYCLES-1.
- Bits are fully independent. Simultaneous transitions on several bits yield simultaneous sw_changed bits and a single any_changed pulse.
- any_changed is registered from the same next-state terms, so it is high in exactly the cycles where sw_changed != 0.
- All outputs are registered. No combinational path from sw_raw to any output.

Optional Feature:
Macro: WASCA_SWITCH_EDGE_LATCH_EN
- Defined:
  - sw_edge_latched[i] sets on the edge where sw_changed[i] is driven 1 and holds until edge_clear[i]=1 at a clk edge.
  - Set has priority over clear in the same cycle.
  - The latch clears to 0 in reset.
- Not defined:
  - sw_edge_latched is tied to 0 and edge_clear is ignored.
  - Ports remain present so integration is unchanged.

Test Plan:
(Bench uses WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VALUE=0.)
- Reset release, sw_raw=8'h00 held 20 cycles → sw_clean=8'h00, sw_changed never asserted, counters 0.
- sw_raw[0] 0→1 sampled at edge k, held → sw_clean=8'h01 after edge k+5; sw_changed=8'h01 and any_changed=1 for exactly one cycle.
- Glitches on sw_raw[3], high for 3 cycles, repeated with 1-cycle lows → sw_clean[3] stays 0, no pulse. A 4-cycle-stable high yields the update per the latency rule.
- sw_raw 8'h00→8'hA5 in a single cycle, held → sw_clean=8'hA5 on one edge, sw_changed=8'hA5 for one cycle, one any_changed pulse.
- reset_n asserted 2 cycles into a pending count on bit 2 → outputs return to reset values immediately. After release with sw_raw[2] still 1, a full count restarts with update at release edge+5.
- With WASCA_SWITCH_EDGE_LATCH_EN: bit 1 toggles → sw_edge_latched=8'h02 persists. edge_clear=8'h02 clears it. edge_clear coincident with a new sw_changed[1] leaves it set.
